// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with occupancy thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo_thr #(
  parameter int N        = 8,
  parameter int DEEP     = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          arst,
  input  logic [N-1:0]  data_in,
  input  logic          w_en,
  input  logic          r_en,
  input  logic          clr_err,
  output logic [N-1:0]  data_o,
  output logic          Full,
  output logic          Empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [DEEP:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 1 << DEEP;

  localparam logic [DEEP:0] AF  = (DEEP+1)'(AF_LEVEL);
  localparam logic [DEEP:0] AE  = (DEEP+1)'(AE_LEVEL);
  localparam logic [DEEP:0] ONE = (DEEP+1)'(1);

  logic [N-1:0]  mem [DEPTH];
  logic [DEEP:0] wptr;
  logic [DEEP:0] rptr;
  logic          push;
  logic          pop;

  // Wrap bit distinguishes full from empty when addresses coincide.
  assign Full  = (wptr[DEEP-1:0] == rptr[DEEP-1:0]) &&
                 (wptr[DEEP] != rptr[DEEP]);
  assign Empty = (wptr == rptr);

  assign push = w_en && !Full;
  assign pop  = r_en && !Empty;

  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);

  // Storage array; intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[DEEP-1:0]] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new offence wins over a clear.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && Full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (r_en && Empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; meaningless while Empty.
  assign data_o = mem[rptr[DEEP-1:0]];
`else
  // Head word captured on pop, held otherwise.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      data_o <= '0;
    end else if (pop) begin
      data_o <= mem[rptr[DEEP-1:0]];
    end
  end
`endif

endmodule
